// File: rtl/recip_issue_arbiter.sv
// Round-robin issue arbiter for one shared, fully pipelined Newton reciprocal unit.
// Tags each issue, delays the tag alongside the unit pipeline, and pulses rsp_valid to the originator.
module recip_issue_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int MANTISSA_SIZE = 23,
  parameter int ITERATIONS    = 3,
  localparam int RECIP_LATENCY = 8*ITERATIONS+1,
  localparam int FLOAT_SIZE    = 1+8+MANTISSA_SIZE,
  localparam int CNT_W         = $clog2(RECIP_LATENCY+2),
  localparam int TAG_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FLOAT_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FLOAT_SIZE-1:0]         recip_in,
  input  logic [FLOAT_SIZE-1:0]         recip_out,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [FLOAT_SIZE-1:0]         rsp_data,
  output logic [CNT_W-1:0]              in_flight,
  output logic                          idle
);

  logic [TAG_W-1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0]       grant;
  logic [TAG_W-1:0]         grant_idx;
  logic                     accept;
  logic                     found;
  int                       cand;

  logic [FLOAT_SIZE-1:0]    recip_in_q, recip_in_d;
  logic                     issue_vld_q, issue_vld_d;
  logic [TAG_W-1:0]         issue_tag_q, issue_tag_d;

  logic [RECIP_LATENCY-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]         tag_q [RECIP_LATENCY];
  logic [TAG_W-1:0]         tag_d [RECIP_LATENCY];

  logic [CNT_W-1:0]         in_flight_q, in_flight_d;
  logic                     rsp_any;

  // Arbitration: first valid requester after the last winner, wrapping at NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    found     = 1'b0;
    cand      = 0;
    if (enable && resetn) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = (int'(ptr_q) + k) % NUM_REQ;
        if (!found && req_valid[cand]) begin
          found       = 1'b1;
          grant       = '0;
          grant[cand] = 1'b1;
          grant_idx   = TAG_W'(cand);
        end
      end
    end
  end

  assign accept    = found;
  assign req_ready = grant;

  // Issue register: operand, tag and valid captured on the accepting edge.
  always_comb begin
    ptr_d       = ptr_q;
    recip_in_d  = recip_in_q;
    issue_tag_d = issue_tag_q;
    issue_vld_d = accept;
    if (accept) begin
      ptr_d       = grant_idx;
      recip_in_d  = req_data[int'(grant_idx)*FLOAT_SIZE +: FLOAT_SIZE];
      issue_tag_d = grant_idx;
    end
  end

  // Tag/valid delay line shadowing the reciprocal pipeline; it never stalls.
  always_comb begin
    vld_d    = {vld_q[RECIP_LATENCY-2:0], issue_vld_q};
    tag_d[0] = issue_tag_q;
    for (int i = 1; i < RECIP_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign rsp_any = vld_q[RECIP_LATENCY-1];

  always_comb begin
    in_flight_d = in_flight_q;
    unique case ({accept, rsp_any})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q       <= TAG_W'(NUM_REQ-1);
      recip_in_q  <= '0;
      issue_vld_q <= 1'b0;
      issue_tag_q <= '0;
      vld_q       <= '0;
      in_flight_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      recip_in_q  <= recip_in_d;
      issue_vld_q <= issue_vld_d;
      issue_tag_q <= issue_tag_d;
      vld_q       <= vld_d;
      in_flight_q <= in_flight_d;
    end
  end

  // Tags are only meaningful under their valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_any) begin
      rsp_valid[tag_q[RECIP_LATENCY-1]] = 1'b1;
    end
  end

  assign rsp_data  = recip_out;
  assign recip_in  = recip_in_q;
  assign in_flight = in_flight_q;
  assign idle      = (in_flight_q == '0) && !accept;

endmodule
